// File: rtl/user_mux.sv
// user_mux: packet-granular round-robin merge of three AXI-Stream inputs.
// Single output register stage; granted port id is stamped into tuser[39:32].
module user_mux #(
    parameter int C_M_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_M_AXIS_TUSER_WIDTH = 128
) (
    input  logic                                axis_aclk,
    input  logic                                axis_resetn,

    input  logic [C_S_AXIS_DATA_WIDTH-1:0]      s_axis_0_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]    s_axis_0_tkeep,
    input  logic [C_M_AXIS_TUSER_WIDTH-1:0]     s_axis_0_tuser,
    input  logic                                s_axis_0_tvalid,
    input  logic                                s_axis_0_tlast,
    output logic                                s_axis_0_tready,

    input  logic [C_S_AXIS_DATA_WIDTH-1:0]      s_axis_1_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]    s_axis_1_tkeep,
    input  logic [C_M_AXIS_TUSER_WIDTH-1:0]     s_axis_1_tuser,
    input  logic                                s_axis_1_tvalid,
    input  logic                                s_axis_1_tlast,
    output logic                                s_axis_1_tready,

    input  logic [C_S_AXIS_DATA_WIDTH-1:0]      s_axis_2_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]    s_axis_2_tkeep,
    input  logic [C_M_AXIS_TUSER_WIDTH-1:0]     s_axis_2_tuser,
    input  logic                                s_axis_2_tvalid,
    input  logic                                s_axis_2_tlast,
    output logic                                s_axis_2_tready,

    output logic [C_M_AXIS_DATA_WIDTH-1:0]      m_axis_tdata,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]    m_axis_tkeep,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]     m_axis_tuser,
    output logic                                m_axis_tvalid,
    output logic                                m_axis_tlast,
    input  logic                                m_axis_tready
);

    localparam int DW = C_S_AXIS_DATA_WIDTH;
    localparam int KW = DW / 8;
    localparam int UW = C_M_AXIS_TUSER_WIDTH;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] PASS = 1'b1;

    logic [0:0]    state;
    logic [1:0]    grant;
    logic [1:0]    rr_ptr;
    logic [1:0]    pick;
    logic          found;
    logic [2:0]    cand;

    logic [DW-1:0] s_data [3];
    logic [KW-1:0] s_keep [3];
    logic [UW-1:0] s_user [3];
    logic [2:0]    s_valid;
    logic [2:0]    s_last;
    logic [2:0]    s_ready;

    logic          out_free;
    logic          xfer;
    logic [UW-1:0] user_sel;

    assign s_data[0] = s_axis_0_tdata;
    assign s_data[1] = s_axis_1_tdata;
    assign s_data[2] = s_axis_2_tdata;
    assign s_keep[0] = s_axis_0_tkeep;
    assign s_keep[1] = s_axis_1_tkeep;
    assign s_keep[2] = s_axis_2_tkeep;
    assign s_user[0] = s_axis_0_tuser;
    assign s_user[1] = s_axis_1_tuser;
    assign s_user[2] = s_axis_2_tuser;
    assign s_valid   = {s_axis_2_tvalid, s_axis_1_tvalid, s_axis_0_tvalid};
    assign s_last    = {s_axis_2_tlast, s_axis_1_tlast, s_axis_0_tlast};

    // Round-robin search starting at rr_ptr, wrapping modulo 3.
    always_comb begin
        found = 1'b0;
        pick  = rr_ptr;
        cand  = 3'd0;
        for (int k = 0; k < 3; k++) begin
            cand = {1'b0, rr_ptr} + 3'(k);
            if (cand >= 3'd3) cand = cand - 3'd3;
            if (!found && s_valid[cand[1:0]]) begin
                found = 1'b1;
                pick  = cand[1:0];
            end
        end
    end

    assign out_free = !m_axis_tvalid || m_axis_tready;

    always_comb begin
        s_ready = 3'b000;
        if (state == PASS && out_free) s_ready = 3'b001 << grant;
    end

    assign s_axis_0_tready = s_ready[0];
    assign s_axis_1_tready = s_ready[1];
    assign s_axis_2_tready = s_ready[2];

    assign xfer = (state == PASS) && out_free && s_valid[grant];

    always_comb begin
        user_sel         = s_user[grant];
        user_sel[39:32]  = {6'b0, grant};
    end

    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            state         <= IDLE;
            grant         <= 2'd0;
            rr_ptr        <= 2'd0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tuser  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (found) begin
                        state <= PASS;
                        grant <= pick;
                    end
                end
                PASS: begin
                    if (xfer && s_last[grant]) begin
                        state  <= IDLE;
                        rr_ptr <= (grant == 2'd2) ? 2'd0 : grant + 2'd1;
                    end
                end
            endcase

            if (xfer) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tdata  <= s_data[grant];
                m_axis_tkeep  <= s_keep[grant];
                m_axis_tuser  <= user_sel;
                m_axis_tlast  <= s_last[grant];
            end else if (m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_user_mux.sv
// tb_user_mux: randomized stimulus against a packet-level round-robin model.
// Each scenario task drives traffic and compares the collected output inline.
module tb_user_mux;

    localparam int DW = 256;
    localparam int KW = DW / 8;
    localparam int UW = 128;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic [UW-1:0] user;
        logic          last;
    } beat_t;

    typedef struct {
        int    port;
        int    gap;
        beat_t b;
    } stim_t;

    logic          clk = 1'b0;
    logic          resetn = 1'b1;
    logic [DW-1:0] s_data [3];
    logic [KW-1:0] s_keep [3];
    logic [UW-1:0] s_user [3];
    logic [2:0]    s_valid = 3'b000;
    logic [2:0]    s_last = 3'b000;
    logic [2:0]    s_rdy;
    logic [DW-1:0] m_data;
    logic [KW-1:0] m_keep;
    logic [UW-1:0] m_user;
    logic          m_valid;
    logic          m_last;
    logic          m_ready = 1'b0;

    always #5 clk = ~clk;

    user_mux dut (
        .axis_aclk       (clk),
        .axis_resetn     (resetn),
        .s_axis_0_tdata  (s_data[0]),
        .s_axis_0_tkeep  (s_keep[0]),
        .s_axis_0_tuser  (s_user[0]),
        .s_axis_0_tvalid (s_valid[0]),
        .s_axis_0_tlast  (s_last[0]),
        .s_axis_0_tready (s_rdy[0]),
        .s_axis_1_tdata  (s_data[1]),
        .s_axis_1_tkeep  (s_keep[1]),
        .s_axis_1_tuser  (s_user[1]),
        .s_axis_1_tvalid (s_valid[1]),
        .s_axis_1_tlast  (s_last[1]),
        .s_axis_1_tready (s_rdy[1]),
        .s_axis_2_tdata  (s_data[2]),
        .s_axis_2_tkeep  (s_keep[2]),
        .s_axis_2_tuser  (s_user[2]),
        .s_axis_2_tvalid (s_valid[2]),
        .s_axis_2_tlast  (s_last[2]),
        .s_axis_2_tready (s_rdy[2]),
        .m_axis_tdata    (m_data),
        .m_axis_tkeep    (m_keep),
        .m_axis_tuser    (m_user),
        .m_axis_tvalid   (m_valid),
        .m_axis_tlast    (m_last),
        .m_axis_tready   (m_ready)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;

    stim_t stim [$];
    beat_t exp_q [$];
    beat_t got [$];
    int    got_cyc [$];

    bit    collect = 1'b0;
    bit    abort = 1'b0;
    int    drv_done;
    int    gap_rdy1;
    int    acc_cyc [3];
    int    stab_err = 0;
    int    rdy_err = 0;
    logic  prev_stall = 1'b0;
    logic [DW+KW+UW+1:0] prev_out = '0;
    logic [0:5] rdy_pat = 6'b100101;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (collect && m_valid && m_ready) begin
            got.push_back('{m_data, m_keep, m_user, m_last});
            got_cyc.push_back(cyc);
        end
        if (collect) begin
            if (prev_stall && prev_out !== {m_data, m_keep, m_user, m_last, m_valid})
                stab_err <= stab_err + 1;
            if ((m_valid && !m_ready && s_rdy != 3'b000) || !$onehot0(s_rdy))
                rdy_err <= rdy_err + 1;
        end
        prev_stall <= m_valid && !m_ready;
        prev_out   <= {m_data, m_keep, m_user, m_last, m_valid};
    end

    function automatic logic [DW-1:0] rnd_wide();
        logic [DW-1:0] r = '0;
        for (int i = 0; i < DW / 32; i++) r = {r[DW-33:0], 32'($urandom)};
        return r;
    endfunction

    task automatic set_port(input int p, input beat_t b, input logic v);
        s_data[p]  = b.data;
        s_keep[p]  = b.keep;
        s_user[p]  = b.user;
        s_last[p]  = b.last;
        s_valid[p] = v;
    endtask

    task automatic add_pkt(input int p, input int len, input int gmax);
        stim_t s;
        logic [DW-1:0] w;
        for (int j = 0; j < len; j++) begin
            w = rnd_wide();
            s.port   = p;
            s.gap    = (j == 0 || gmax == 0) ? 0 : int'($urandom_range(gmax));
            s.b.data = rnd_wide();
            s.b.keep = KW'($urandom);
            s.b.user = w[UW-1:0];
            s.b.user[39:32] = 8'hFF;
            s.b.last = (j == len - 1);
            stim.push_back(s);
        end
    endtask

    function automatic int find_next(input int p, input int from);
        for (int i = from; i < stim.size(); i++)
            if (stim[i].port == p) return i;
        return -1;
    endfunction

    // Packet-level model: whole packets leave in round-robin order over
    // ports that still have packets queued, starting at port 0.
    task automatic build_model();
        int    rr;
        int    i;
        int    p;
        int    pos [3];
        bit    found;
        beat_t b;
        exp_q.delete();
        rr  = 0;
        pos = '{0, 0, 0};
        do begin
            found = 1'b0;
            for (int k = 0; k < 3 && !found; k++) begin
                p = (rr + k) % 3;
                i = find_next(p, pos[p]);
                if (i >= 0) begin
                    found = 1'b1;
                    do begin
                        b = stim[i].b;
                        b.user[39:32] = 8'(p);
                        exp_q.push_back(b);
                        pos[p] = i + 1;
                        i = stim[i].b.last ? -1 : find_next(p, i + 1);
                    end while (i >= 0);
                    rr = (p + 1) % 3;
                end
            end
        end while (found);
    endtask

    task automatic drive_port(input int p);
        beat_t z = '0;
        bit    acc;
        foreach (stim[i]) begin
            if (stim[i].port != p) continue;
            if (abort) break;
            if (stim[i].gap > 0) begin
                set_port(p, z, 1'b0);
                repeat (stim[i].gap) begin
                    @(negedge clk);
                    if (s_rdy[1]) gap_rdy1++;
                    @(posedge clk); #1;
                end
            end
            set_port(p, stim[i].b, 1'b1);
            acc = 1'b0;
            while (!acc && !abort) begin
                @(negedge clk);
                acc = s_valid[p] && s_rdy[p];
                if (acc && acc_cyc[p] < 0) acc_cyc[p] = cyc;
                @(posedge clk); #1;
            end
        end
        set_port(p, z, 1'b0);
        drv_done++;
    endtask

    task automatic run_traffic(input int mode, input int budget);
        int c = 0;
        int n_exp = exp_q.size();
        drv_done = 0;
        abort    = 1'b0;
        gap_rdy1 = 0;
        got.delete();
        got_cyc.delete();
        for (int p = 0; p < 3; p++) acc_cyc[p] = -1;
        collect = 1'b1;
        fork
            drive_port(0);
            drive_port(1);
            drive_port(2);
            begin
                while (!(drv_done == 3 && got.size() >= n_exp) && c < budget) begin
                    case (mode)
                        0:       m_ready = 1'b1;
                        1:       m_ready = ($urandom_range(99) < 70);
                        default: m_ready = (c >= 2 && c < 8) ? rdy_pat[c-2] : 1'b1;
                    endcase
                    @(posedge clk); #1;
                    c++;
                end
                if (c >= budget) abort = 1'b1;
            end
        join
        collect = 1'b0;
    endtask

    task automatic do_reset();
        beat_t z = '0;
        for (int p = 0; p < 3; p++) set_port(p, z, 1'b0);
        m_ready = 1'b0;
        @(posedge clk); #2;
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        #3 resetn = 1'b0;
        #1;
        total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL rst valid: got %b want 0", m_valid); end
        total++; if (m_last !== 1'b0) begin bad++; $display("FAIL rst last: got %b want 0", m_last); end
        total++; if (m_data !== '0) begin bad++; $display("FAIL rst data: got %h want 0", m_data); end
        total++; if (m_keep !== '0) begin bad++; $display("FAIL rst keep: got %h want 0", m_keep); end
        total++; if (m_user !== '0) begin bad++; $display("FAIL rst user: got %h want 0", m_user); end
        total++; if (s_rdy !== 3'b000) begin bad++; $display("FAIL rst tready: got %b want 000", s_rdy); end
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_single_port();
        do_reset();
        stim.delete();
        add_pkt(1, 4, 0);
        build_model();
        run_traffic(0, 200);
        total++;
        if (got.size() !== exp_q.size()) begin
            bad++; $display("FAIL single count: got %0d want %0d", got.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < got.size()) begin
            total++;
            if (got[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL single beat %0d: got last=%b id=%h data=%h want last=%b id=%h data=%h",
                         i, got[i].last, got[i].user[39:32], got[i].data,
                         exp_q[i].last, exp_q[i].user[39:32], exp_q[i].data);
            end
        end
        if (got.size() == 4) begin
            total++;
            if (got_cyc[0] !== acc_cyc[1] + 1) begin
                bad++; $display("FAIL single latency: got cycle %0d want %0d", got_cyc[0], acc_cyc[1] + 1);
            end
            total++;
            if (got_cyc[3] - got_cyc[0] !== 3) begin
                bad++; $display("FAIL single span: got %0d want 3", got_cyc[3] - got_cyc[0]);
            end
        end
    endtask

    task automatic test_round_robin();
        int want;
        do_reset();
        stim.delete();
        for (int r = 0; r < 2; r++)
            for (int p = 0; p < 3; p++) add_pkt(p, 2, 0);
        build_model();
        run_traffic(0, 300);
        total++;
        if (got.size() !== exp_q.size()) begin
            bad++; $display("FAIL rr count: got %0d want %0d", got.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < got.size()) begin
            total++;
            if (got[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL rr beat %0d: got last=%b id=%h data=%h want last=%b id=%h data=%h",
                         i, got[i].last, got[i].user[39:32], got[i].data,
                         exp_q[i].last, exp_q[i].user[39:32], exp_q[i].data);
            end
        end
        for (int i = 1; i < got.size(); i++) begin
            want = got[i-1].last ? 2 : 1;
            total++;
            if (got_cyc[i] - got_cyc[i-1] !== want) begin
                bad++; $display("FAIL rr spacing %0d: got %0d want %0d", i, got_cyc[i] - got_cyc[i-1], want);
            end
        end
    endtask

    task automatic test_backpressure();
        int s0;
        int r0;
        do_reset();
        stim.delete();
        add_pkt(2, 3, 0);
        build_model();
        s0 = stab_err;
        r0 = rdy_err;
        run_traffic(2, 200);
        total++;
        if (got.size() !== exp_q.size()) begin
            bad++; $display("FAIL bp count: got %0d want %0d", got.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < got.size()) begin
            total++;
            if (got[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL bp beat %0d: got last=%b id=%h data=%h want last=%b id=%h data=%h",
                         i, got[i].last, got[i].user[39:32], got[i].data,
                         exp_q[i].last, exp_q[i].user[39:32], exp_q[i].data);
            end
        end
        total++; if (stab_err - s0 !== 0) begin bad++; $display("FAIL bp stable: got %0d changes want 0", stab_err - s0); end
        total++; if (rdy_err - r0 !== 0) begin bad++; $display("FAIL bp tready: got %0d bad cycles want 0", rdy_err - r0); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        stim.delete();
        add_pkt(0, 1, 0);
        add_pkt(0, 1, 0);
        stim[0].b.data = DW'(32'hA);
        stim[1].b.data = DW'(32'hB);
        build_model();
        run_traffic(0, 200);
        total++;
        if (got.size() !== exp_q.size()) begin
            bad++; $display("FAIL b2b count: got %0d want %0d", got.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < got.size()) begin
            total++;
            if (got[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL b2b beat %0d: got last=%b id=%h data=%h want last=%b id=%h data=%h",
                         i, got[i].last, got[i].user[39:32], got[i].data,
                         exp_q[i].last, exp_q[i].user[39:32], exp_q[i].data);
            end
        end
        if (got.size() == 2) begin
            total++;
            if (got_cyc[1] - got_cyc[0] !== 2) begin
                bad++; $display("FAIL b2b gap: got %0d want 2", got_cyc[1] - got_cyc[0]);
            end
        end
    endtask

    task automatic test_reset_mid();
        beat_t b;
        beat_t z = '0;
        bit    acc;
        int    w;
        do_reset();
        m_ready = 1'b1;
        for (int j = 0; j < 2; j++) begin
            b.data = rnd_wide();
            b.keep = '1;
            b.user = '1;
            b.last = 1'b0;
            set_port(1, b, 1'b1);
            acc = 1'b0;
            w = 0;
            while (!acc && w < 10) begin
                @(negedge clk);
                acc = s_rdy[1];
                @(posedge clk); #1;
                w++;
            end
        end
        total++; if (m_valid !== 1'b1) begin bad++; $display("FAIL mid pre-reset valid: got %b want 1", m_valid); end
        #2 resetn = 1'b0;
        #1;
        total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL mid valid: got %b want 0", m_valid); end
        total++; if (m_last !== 1'b0) begin bad++; $display("FAIL mid last: got %b want 0", m_last); end
        total++; if (m_data !== '0) begin bad++; $display("FAIL mid data: got %h want 0", m_data); end
        total++; if (m_keep !== '0) begin bad++; $display("FAIL mid keep: got %h want 0", m_keep); end
        total++; if (m_user !== '0) begin bad++; $display("FAIL mid user: got %h want 0", m_user); end
        total++; if (s_rdy !== 3'b000) begin bad++; $display("FAIL mid tready: got %b want 000", s_rdy); end
        set_port(1, z, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk); #1;
        stim.delete();
        add_pkt(1, 2, 0);
        add_pkt(0, 2, 0);
        build_model();
        run_traffic(0, 200);
        total++;
        if (got.size() !== exp_q.size()) begin
            bad++; $display("FAIL mid count: got %0d want %0d", got.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < got.size()) begin
            total++;
            if (got[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL mid beat %0d: got last=%b id=%h data=%h want last=%b id=%h data=%h",
                         i, got[i].last, got[i].user[39:32], got[i].data,
                         exp_q[i].last, exp_q[i].user[39:32], exp_q[i].data);
            end
        end
        if (got.size() > 0) begin
            total++;
            if (got[0].user[39:32] !== 8'h00) begin
                bad++; $display("FAIL mid first grant: got %h want 00", got[0].user[39:32]);
            end
        end
    endtask

    task automatic test_stall_hold();
        do_reset();
        stim.delete();
        add_pkt(0, 4, 0);
        add_pkt(1, 2, 0);
        stim[2].gap = 3;
        build_model();
        run_traffic(0, 200);
        total++;
        if (got.size() !== exp_q.size()) begin
            bad++; $display("FAIL hold count: got %0d want %0d", got.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < got.size()) begin
            total++;
            if (got[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL hold beat %0d: got last=%b id=%h data=%h want last=%b id=%h data=%h",
                         i, got[i].last, got[i].user[39:32], got[i].data,
                         exp_q[i].last, exp_q[i].user[39:32], exp_q[i].data);
            end
        end
        total++;
        if (gap_rdy1 !== 0) begin
            bad++; $display("FAIL hold port1 tready: got %0d cycles want 0", gap_rdy1);
        end
    endtask

    task automatic test_random();
        int s0;
        int r0;
        for (int round = 0; round < 3; round++) begin
            do_reset();
            stim.delete();
            for (int n = 0; n < 9; n++)
                if ($urandom_range(99) < 70)
                    add_pkt(int'($urandom_range(2)), int'($urandom_range(5, 1)), 2);
            build_model();
            s0 = stab_err;
            r0 = rdy_err;
            run_traffic(1, 3000);
            total++;
            if (got.size() !== exp_q.size()) begin
                bad++; $display("FAIL rand%0d count: got %0d want %0d", round, got.size(), exp_q.size());
            end
            foreach (exp_q[i]) if (i < got.size()) begin
                total++;
                if (got[i] !== exp_q[i]) begin
                    bad++;
                    $display("FAIL rand%0d beat %0d: got last=%b id=%h data=%h want last=%b id=%h data=%h",
                             round, i, got[i].last, got[i].user[39:32], got[i].data,
                             exp_q[i].last, exp_q[i].user[39:32], exp_q[i].data);
                end
            end
            total++; if (stab_err - s0 !== 0) begin bad++; $display("FAIL rand%0d stable: got %0d want 0", round, stab_err - s0); end
            total++; if (rdy_err - r0 !== 0) begin bad++; $display("FAIL rand%0d tready: got %0d want 0", round, rdy_err - r0); end
        end
    endtask

    initial begin
        test_reset();
        test_single_port();
        test_round_robin();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_stall_hold();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/user_mux.md
USER_MUX -- requirements
Module: user_mux

Interface
REQ-001 SHALL have parameter C_M_AXIS_DATA_WIDTH, default 256, master tdata width.
REQ-002 SHALL have parameter C_S_AXIS_DATA_WIDTH, default 256, slave tdata width; the block is instantiated only with this equal to C_M_AXIS_DATA_WIDTH.
REQ-003 SHALL have parameter C_M_AXIS_TUSER_WIDTH, default 128, tuser width on all ports; minimum 40.
REQ-004 SHALL have port axis_aclk, input, 1, the single clock; all logic is rising-edge.
REQ-005 SHALL have port axis_resetn, input, 1, reset; asynchronous, active-low.
REQ-006 SHALL have, for each i in 0..2: s_axis_i_tdata input DATA_WIDTH; s_axis_i_tkeep input DATA_WIDTH/8; s_axis_i_tuser input TUSER_WIDTH; s_axis_i_tvalid input 1; s_axis_i_tlast input 1; s_axis_i_tready output 1. These are per-user input streams.
REQ-007 SHALL have m_axis_tdata output DATA_WIDTH, m_axis_tkeep output DATA_WIDTH/8, m_axis_tuser output TUSER_WIDTH, m_axis_tvalid output 1, m_axis_tlast output 1, and m_axis_tready input 1; this is the merged stream.

Function
REQ-008 SHALL merge the three slave streams into m_axis at packet granularity; beats of different packets never interleave.
REQ-009 SHALL use a two-state FSM: IDLE (no grant) and PASS (grant held by one port).
REQ-010 In IDLE, SHALL select the first port with tvalid=1, searching round-robin from rr_ptr; it SHALL register the grant and enter PASS on the next edge; with no tvalid it SHALL stay in IDLE.
REQ-011 In IDLE, all s_axis_i_tready SHALL be 0.
REQ-012 s_axis_i_tready SHALL equal (state==PASS && grant==i && (!m_axis_tvalid || m_axis_tready)); it is combinational from registered state plus m_axis_tready, and is 0 for non-granted ports.
REQ-013 Output SHALL be a single register stage: on a slave transfer (tvalid && tready), tdata/tkeep/tlast/tuser SHALL be loaded into the m_axis registers and m_axis_tvalid set to 1 on the next edge; latency is exactly 1 cycle from slave acceptance to m_axis_tvalid.
REQ-014 m_axis_tvalid SHALL clear on an edge where m_axis_tready=1 and no new slave beat is accepted; while m_axis_tvalid=1 and m_axis_tready=0, all m_axis outputs SHALL hold stable.
REQ-015 m_axis_tuser[39:32] SHALL be set to the granted port index zero-extended to 8 bits (8'h00/8'h01/8'h02); all other tuser bits SHALL pass through unchanged.
REQ-016 On acceptance of a slave beat with tlast=1, SHALL return to IDLE and set rr_ptr to (grant+1) mod 3 on the same edge.
REQ-017 Single-beat packets (tvalid and tlast on the first beat) SHALL be handled: one PASS cycle, then IDLE.
REQ-018 Throughput SHALL be one beat per cycle within a packet while m_axis_tready=1; exactly one IDLE bubble cycle SHALL occur between packets.
REQ-019 Once in PASS, a deasserted tvalid on the granted port SHALL hold PASS and the grant (no timeout); the other ports stay stalled.
REQ-020 A port whose tvalid drops while in IDLE before the grant edge is not granted; arbitration uses tvalid sampled at that edge only.

Reset
REQ-021 While axis_resetn=0 (asynchronously): state=IDLE, grant=0, rr_ptr=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata/tkeep/tuser=0, and all s_axis_i_tready=0.
REQ-022 Reset asserted mid-packet SHALL discard the in-flight beat and the grant; after release, the block re-arbitrates from rr_ptr=0 with no partial-packet recovery.

Verification
REQ-023 Port 1 sends a 4-beat packet with tuser[39:32]=8'hFF, m_axis_tready=1 -> 4 output beats, first one cycle after the first slave acceptance, tuser[39:32]=8'h01, tlast only on beat 4, tdata identical.
REQ-024 All three ports hold 2-beat packets continuously from reset -> output packet order 0,1,2,0,1,2 with one idle cycle between packets and no interleaving.
REQ-025 Port 2 sends a 3-beat packet while m_axis_tready toggles 1,0,0,1,0,1 -> no beat is lost or duplicated, outputs are stable during stalls, and s_axis_2_tready=0 whenever m_axis_tvalid=1 and m_axis_tready=0.
REQ-026 Port 0 sends back-to-back single-beat packets with tdata 0xA then 0xB, other ports idle -> 0xA, then one idle cycle, then 0xB, each with tlast=1 and tuser[39:32]=8'h00.
REQ-027 axis_resetn pulses low at beat 2 of a 5-beat packet on port 1 -> all outputs are 0 immediately (asynchronously), and after release a port-0 packet is granted first.
REQ-028 Port 0's tvalid drops for 3 cycles mid-packet while port 1 is valid -> grant stays on port 0, s_axis_1_tready=0 throughout, and port 1 is served after port 0's tlast.
